// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues fixed-latency imem reads and buffers the returned
// words in a 2-entry FIFO for decode; halts on an all-zero word, redirect flushes and restarts.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc,
    output logic        halted
);
    typedef enum logic {RUN, HALT} state_t;
    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_req_addr;
    logic        r_inflight;
    logic [1:0]  r_count;
    logic [31:0] r_ins [FIFO_DEPTH];
    logic [31:0] r_pcs [FIFO_DEPTH];
    logic        w_pop, w_zero, w_enq, w_wr;
    logic [2:0]  w_credit;
    always_comb begin
        w_pop       = out_valid && out_ready && !redirect_valid;
        w_zero      = r_inflight && (imem_rdata == 32'h0);
        w_enq       = r_inflight && !redirect_valid;
        w_wr        = r_count[1] | (r_count[0] & !w_pop);
        // slots already owned by buffered or inflight words, minus the one leaving now
        w_credit    = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, out_valid && out_ready};
        imem_req    = !rst && r_state == RUN && !redirect_valid && !w_zero && w_credit < 3'd2;
        w_state_nxt = redirect_valid ? RUN : w_enq && w_zero ? HALT : r_state;
    end
    assign imem_addr       = r_pc;
    assign out_valid       = r_count != 2'd0;
    assign out_instruction = out_valid ? r_ins[0] : 32'h0;
    assign out_pc          = out_valid ? r_pcs[0] : 32'h0;
    assign halted          = r_state == HALT;
    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_pc       <= rst ? RESET_PC : redirect_pc & ~32'd3;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_count    <= r_count - {1'b0, w_pop} + {1'b0, w_enq};
            r_inflight <= imem_req;
            if (imem_req) begin
                r_pc       <= r_pc + 32'd4;
                r_req_addr <= r_pc;
            end
        end
    end
    always_ff @(posedge clk) begin
        assert (rst || !(w_enq && !w_pop && r_count == 2'(FIFO_DEPTH)));
        if (w_pop) begin
            r_ins[0] <= r_ins[1];
            r_pcs[0] <= r_pcs[1];
        end
        if (w_enq) begin
            r_ins[w_wr] <= imem_rdata;
            r_pcs[w_wr] <= r_req_addr;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with literal expectations plus a queue-based
// reference model compared against the DUT every cycle outside reset.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, imem_req, redirect_valid, out_valid, out_ready, halted;
    logic [31:0] imem_addr, redirect_pc, out_instruction, out_pc;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    int checks = 0, errors = 0;
    logic [31:0] mem [logic [31:0]];
    typedef struct {logic [31:0] pc; logic [31:0] ins;} ent_t;
    ent_t q[$];
    logic [31:0] m_pc, m_ia;
    bit m_inf, m_halt, started;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
        .out_pc(out_pc), .halted(halted)
    );

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : a + 32'h13;
    endfunction

    always @(posedge clk) imem_rdata <= imem_req ? rd(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    // Reference model: evaluates the cycle at the negedge, then advances to the next posedge.
    always @(negedge clk) begin
        bit pop, zr, req;
        logic [31:0] ep, ei;
        pop = q.size() > 0 && out_ready;
        zr  = m_inf && imem_rdata == 32'h0;
        req = !m_halt && !redirect_valid && !zr && (q.size() + int'(m_inf) - int'(pop)) < 2;
        ep = 32'h0;
        ei = 32'h0;
        if (q.size() > 0) begin
            ep = q[0].pc;
            ei = q[0].ins;
        end
        if (started && !rst) begin
            chk("m_req", imem_req, req);
            chk("m_addr", imem_addr, m_pc);
            chk("m_valid", out_valid, q.size() > 0);
            chk("m_halted", halted, m_halt);
            chk("m_pc", out_pc, ep);
            chk("m_ins", out_instruction, ei);
        end
        if (rst) begin
            started = 1;
            m_pc = 32'h0; m_inf = 0; m_halt = 0;
            q.delete();
        end else if (redirect_valid) begin
            m_pc = redirect_pc & ~32'd3; m_inf = 0; m_halt = 0;
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (m_inf) q.push_back('{m_ia, imem_rdata});
            if (zr) m_halt = 1;
            m_inf = req;
            if (req) begin
                m_ia = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end
    end

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        mem[32'h4] = 32'h0010_0093;
        mem[32'h8] = 32'h0020_0113;
        rst = 1; redirect_valid = 0; redirect_pc = 32'h0; out_ready = 1;
        adv(2); rst = 0;
        @(negedge clk);
        chk("c0_req", imem_req, 1); chk("c0_addr", imem_addr, 0);
        chk("c0_valid", out_valid, 0); chk("c0_ins", out_instruction, 0);
        adv(1); @(negedge clk);
        chk("c1_valid", out_valid, 0); chk("c1_addr", imem_addr, 32'h4);
        adv(1); @(negedge clk);
        chk("c2_valid", out_valid, 1); chk("c2_pc", out_pc, 0); chk("c2_ins", out_instruction, 32'h13);
        adv(1); @(negedge clk);
        chk("c3_pc", out_pc, 32'h4); chk("c3_ins", out_instruction, 32'h0010_0093);
        adv(1); @(negedge clk);
        chk("c4_pc", out_pc, 32'h8); chk("c4_ins", out_instruction, 32'h0020_0113);
        // stall for five cycles
        adv(1); out_ready = 0;
        @(negedge clk);
        chk("s5_pc", out_pc, 32'hC); chk("s5_req", imem_req, 0);
        adv(4); @(negedge clk);
        chk("s9_pc", out_pc, 32'hC); chk("s9_valid", out_valid, 1); chk("s9_req", imem_req, 0);
        adv(1); out_ready = 1;
        @(negedge clk);
        chk("s10_pc", out_pc, 32'hC); chk("s10_req", imem_req, 1); chk("s10_addr", imem_addr, 32'h14);
        adv(1); @(negedge clk); chk("s11_pc", out_pc, 32'h10);
        adv(1); @(negedge clk); chk("s12_pc", out_pc, 32'h14);
        // redirect with a buffered word and a request inflight
        adv(1); redirect_valid = 1; redirect_pc = 32'h0000_0102;
        @(negedge clk);
        chk("r0_req", imem_req, 0); chk("r0_pc", out_pc, 32'h18);
        adv(1); redirect_valid = 0;
        @(negedge clk);
        chk("r1_req", imem_req, 1); chk("r1_addr", imem_addr, 32'h100); chk("r1_valid", out_valid, 0);
        adv(1); @(negedge clk); chk("r2_valid", out_valid, 0);
        adv(1); @(negedge clk);
        chk("r3_pc", out_pc, 32'h100); chk("r3_ins", out_instruction, 32'h113);
        // halt on zero word at 0xC
        mem[32'hC] = 32'h0;
        adv(1); rst = 1;
        adv(1); rst = 0;
        adv(4); @(negedge clk);
        chk("h4_req", imem_req, 0); chk("h4_pc", out_pc, 32'h8); chk("h4_halted", halted, 0);
        adv(1); @(negedge clk);
        chk("h5_halted", halted, 1); chk("h5_pc", out_pc, 32'hC); chk("h5_ins", out_instruction, 0);
        chk("h5_valid", out_valid, 1); chk("h5_req", imem_req, 0); chk("h5_addr", imem_addr, 32'h10);
        adv(1); @(negedge clk);
        chk("h6_valid", out_valid, 0); chk("h6_halted", halted, 1);
        adv(3); @(negedge clk);
        chk("h9_req", imem_req, 0); chk("h9_halted", halted, 1);
        adv(1); redirect_valid = 1; redirect_pc = 32'h20;
        @(negedge clk);
        chk("hr_req", imem_req, 0); chk("hr_halted", halted, 1);
        adv(1); redirect_valid = 0;
        @(negedge clk);
        chk("hr1_halted", halted, 0); chk("hr1_req", imem_req, 1); chk("hr1_addr", imem_addr, 32'h20);
        adv(2); @(negedge clk);
        chk("hr3_pc", out_pc, 32'h20); chk("hr3_ins", out_instruction, 32'h33);
        // address wrap
        adv(1); redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        adv(1); redirect_valid = 0;
        @(negedge clk);
        chk("w1_req", imem_req, 1); chk("w1_addr", imem_addr, 32'hFFFF_FFFC);
        adv(1); @(negedge clk);
        chk("w2_req", imem_req, 1); chk("w2_addr", imem_addr, 32'h0);
        adv(1); @(negedge clk);
        chk("w3_pc", out_pc, 32'hFFFF_FFFC); chk("w3_ins", out_instruction, 32'h0000_000F);
        // reset with one buffered word and one inflight
        adv(1); rst = 1;
        @(negedge clk);
        chk("x0_pc", out_pc, 32'h0); chk("x0_valid", out_valid, 1); chk("x0_req", imem_req, 0);
        adv(1); rst = 0;
        @(negedge clk);
        chk("x1_valid", out_valid, 0); chk("x1_req", imem_req, 1); chk("x1_addr", imem_addr, 32'h0);
        chk("x1_halted", halted, 0);
        adv(1); @(negedge clk); chk("x2_valid", out_valid, 0);
        adv(1); @(negedge clk);
        chk("x3_pc", out_pc, 32'h0); chk("x3_ins", out_instruction, 32'h13);
        adv(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
